// File: rtl/mips150_io_ctrl.sv
// Memory-map decode, UART RX/TX byte FIFOs and cycle/instruction counters for the MIPS150 X stage.
// Define MIPS150_IO_COUNTERS_EN to build the CYCLES/INSTRS counters and the CNTCLR register.
module mips150_io_ctrl #(
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [3:0]  store_mask,
  input  logic [31:0] store_data,
  input  logic        load_en,
  input  logic        instr_valid,
  output logic [3:0]  dmem_we,
  output logic [3:0]  imem_we,
  output logic        load_io_sel,
  output logic [31:0] io_rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_INC = (RX_AW+1)'(1);
  localparam logic [TX_AW:0] TX_INC = (TX_AW+1)'(1);

  // Region decode on addr[31:28]: 1=DMEM, 2=IMEM (write only), 3=both, 8=IO.
  logic [3:0] region;
  logic [7:0] io_off;
  logic       dmem_hit, imem_hit, io_hit, io_load, io_store;

  assign region   = addr[31:28];
  assign io_off   = addr[7:0];
  assign dmem_hit = (region == 4'h1) || (region == 4'h3);
  assign imem_hit = (region == 4'h2) || (region == 4'h3);
  assign io_hit   = (region == 4'h8);
  assign io_load  = !rst && io_hit && load_en;
  assign io_store = !rst && io_hit && (store_mask != 4'b0000);

  assign dmem_we     = (!rst && dmem_hit) ? store_mask : 4'b0000;
  assign imem_we     = (!rst && imem_hit) ? store_mask : 4'b0000;
  assign load_io_sel = io_hit;

  // Both byte streams use valid/ready: a byte moves on a clock edge where valid
  // and ready are both high; neither side transfers while rst is high.
  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [RX_AW:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic             rx_empty, rx_full, rx_push, rx_pop;
  logic [7:0]       rx_head;

  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q == {~rx_rd_q[RX_AW], rx_rd_q[RX_AW-1:0]});
  assign rx_head  = rx_mem_q[rx_rd_q[RX_AW-1:0]];
  assign rx_ready = !rst && !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = io_load && (io_off == 8'h04) && !rx_empty;

  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [TX_AW:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic             tx_empty, tx_full, tx_push_req, tx_push, tx_pop;
  logic             tx_ovf_q, tx_ovf_d;

  assign tx_empty    = (tx_wr_q == tx_rd_q);
  assign tx_full     = (tx_wr_q == {~tx_rd_q[TX_AW], tx_rd_q[TX_AW-1:0]});
  assign tx_valid    = !rst && !tx_empty;
  assign tx_data     = tx_valid ? tx_mem_q[tx_rd_q[TX_AW-1:0]] : 8'h00;
  assign tx_pop      = tx_valid && tx_ready;
  assign tx_push_req = io_store && (io_off == 8'h0C) && store_mask[0];
  // Fullness is judged before this cycle's pop, so a push into a full FIFO drops even if a pop frees a slot.
  assign tx_push     = tx_push_req && !tx_full;

  always_comb begin
    rx_wr_d  = rx_push ? rx_wr_q + RX_INC : rx_wr_q;
    rx_rd_d  = rx_pop  ? rx_rd_q + RX_INC : rx_rd_q;
    tx_wr_d  = tx_push ? tx_wr_q + TX_INC : tx_wr_q;
    tx_rd_d  = tx_pop  ? tx_rd_q + TX_INC : tx_rd_q;
    tx_ovf_d = tx_ovf_q;
    if (tx_push_req && tx_full)
      tx_ovf_d = 1'b1;
    else if (io_store && (io_off == 8'h08))
      tx_ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_ovf_q <= 1'b0;
    end else begin
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      tx_ovf_q <= tx_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_q[RX_AW-1:0]] <= rx_data;
    if (tx_push) tx_mem_q[tx_wr_q[TX_AW-1:0]] <= store_data[7:0];
  end

  logic [31:0] cycles_rd, instrs_rd;
  logic        unused_ok;

`ifdef MIPS150_IO_COUNTERS_EN
  logic [31:0] cycles_q, cycles_d, instrs_q, instrs_d;
  logic        cnt_clr;

  // A CNTCLR store wins over the same-cycle increment.
  assign cnt_clr = io_store && (io_off == 8'h18);

  always_comb begin
    cycles_d = cnt_clr ? 32'd0 : cycles_q + 32'd1;
    instrs_d = cnt_clr ? 32'd0 : (instr_valid ? instrs_q + 32'd1 : instrs_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_q <= 32'd0;
      instrs_q <= 32'd0;
    end else begin
      cycles_q <= cycles_d;
      instrs_q <= instrs_d;
    end
  end

  assign cycles_rd = cycles_q;
  assign instrs_rd = instrs_q;
  assign unused_ok = ^{addr[27:8], store_data[31:8]};
`else
  assign cycles_rd = 32'd0;
  assign instrs_rd = 32'd0;
  assign unused_ok = ^{addr[27:8], store_data[31:8], instr_valid};
`endif

  always_comb begin
    io_rdata = 32'd0;
    if (!rst && io_hit) begin
      case (io_off)
        8'h00:   io_rdata = {31'd0, !rx_empty};
        8'h04:   io_rdata = rx_empty ? 32'd0 : {24'd0, rx_head};
        8'h08:   io_rdata = {30'd0, tx_ovf_q, !tx_full};
        8'h10:   io_rdata = cycles_rd;
        8'h14:   io_rdata = instrs_rd;
        default: io_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips150_io_ctrl.sv
// Directed bench for mips150_io_ctrl: decode, RX/TX FIFOs, counters and reset behaviour.
module tb_mips150_io_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [3:0]  store_mask;
  logic [31:0] store_data;
  logic        load_en;
  logic        instr_valid;
  logic [3:0]  dmem_we;
  logic [3:0]  imem_we;
  logic        load_io_sel;
  logic [31:0] io_rdata;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

`ifdef MIPS150_IO_COUNTERS_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd;

  mips150_io_ctrl #(.RX_DEPTH(4), .TX_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .store_mask(store_mask), .store_data(store_data),
    .load_en(load_en), .instr_valid(instr_valid), .dmem_we(dmem_we), .imem_we(imem_we),
    .load_io_sel(load_io_sel), .io_rdata(io_rdata), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    addr        = 32'd0;
    store_mask  = 4'd0;
    store_data  = 32'd0;
    load_en     = 1'b0;
    instr_valid = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'd0;
  endtask

  // Called at a negedge; samples the combinational read, then lets one edge pass.
  task automatic io_read(input logic [7:0] off, output logic [31:0] data);
    addr    = {24'h800000, off};
    load_en = 1'b1;
    #1 data = io_rdata;
    @(negedge clk);
    addr    = 32'd0;
    load_en = 1'b0;
  endtask

  task automatic io_write(input logic [7:0] off, input logic [31:0] data);
    addr       = {24'h800000, off};
    store_mask = 4'hF;
    store_data = data;
    @(negedge clk);
    addr       = 32'd0;
    store_mask = 4'd0;
    store_data = 32'd0;
  endtask

  task automatic rx_send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    tx_ready = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);

    // Outputs held quiet while in reset, even with a store and IO address applied.
    addr = 32'h1000_0000; store_mask = 4'hF; #1;
    check_eq("rst_dmem_we", dmem_we, 32'h0);
    check_eq("rst_imem_we", imem_we, 32'h0);
    check_eq("rst_rx_ready", rx_ready, 32'h0);
    check_eq("rst_tx_valid", tx_valid, 32'h0);
    check_eq("rst_tx_data", tx_data, 32'h0);
    addr = 32'h8000_0008; store_mask = 4'h0; load_en = 1'b1; #1;
    check_eq("rst_io_rdata", io_rdata, 32'h0);
    check_eq("rst_load_io_sel", load_io_sel, 32'h1);
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    #1 check_eq("post_rst_rx_ready", rx_ready, 32'h1);

    // Counters: ten edges since reset release.
    repeat (10) @(negedge clk);
    io_read(8'h10, rd); check_eq("cycles_10", rd, CNT_ON ? 32'd10 : 32'd0);
    instr_valid = 1'b1;
    repeat (3) @(negedge clk);
    instr_valid = 1'b0;
    io_read(8'h14, rd); check_eq("instrs_3", rd, CNT_ON ? 32'd3 : 32'd0);
    io_write(8'h18, 32'd0);
    io_read(8'h10, rd); check_eq("cycles_clr", rd, 32'd0);
    io_read(8'h14, rd); check_eq("instrs_clr", rd, 32'd0);
`ifdef MIPS150_IO_COUNTERS_EN
    force dut.cycles_q = 32'hFFFF_FFFF;
    addr = 32'h8000_0010; #1;
    check_eq("cycles_max", io_rdata, 32'hFFFF_FFFF);
    release dut.cycles_q;
    @(negedge clk); #1;
    check_eq("cycles_wrap", io_rdata, 32'd0);
    drive_idle();
`endif
    io_read(8'h00, rd); check_eq("rxctl_reset", rd, 32'h0);
    io_read(8'h08, rd); check_eq("txctl_reset", rd, 32'h1);

    // Address decode.
    addr = 32'h1000_0004; store_mask = 4'hF; #1;
    check_eq("dmem_we_r1", dmem_we, 32'hF);
    check_eq("imem_we_r1", imem_we, 32'h0);
    check_eq("io_sel_r1", load_io_sel, 32'h0);
    addr = 32'h3000_0004; #1;
    check_eq("dmem_we_r3", dmem_we, 32'hF);
    check_eq("imem_we_r3", imem_we, 32'hF);
    addr = 32'h2000_0000; store_mask = 4'b0101; #1;
    check_eq("dmem_we_r2", dmem_we, 32'h0);
    check_eq("imem_we_r2", imem_we, 32'h5);
    addr = 32'h5000_0000; store_mask = 4'hF; #1;
    check_eq("dmem_we_r5", dmem_we, 32'h0);
    check_eq("imem_we_r5", imem_we, 32'h0);
    drive_idle();
    @(negedge clk);

    // RX: five bytes offered, four accepted.
    for (int i = 0; i < 5; i++) begin
      rx_data  = 8'(8'h41 + i);
      rx_valid = 1'b1;
      #1 check_eq("rx_ready_fill", rx_ready, (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) exp_q.push_back({24'd0, rx_data});
      @(negedge clk);
    end
    rx_valid = 1'b0;
    io_read(8'h00, rd); check_eq("rxctl_full", rd, 32'h1);
    for (int i = 0; i < 4; i++) begin
      io_read(8'h04, rd); check_eq("rx_pop", rd, exp_q.pop_front());
    end
    io_read(8'h04, rd); check_eq("rx_pop_empty", rd, 32'h0);
    io_read(8'h00, rd); check_eq("rxctl_empty", rd, 32'h0);

    // RX full with a same-cycle pop: the offered byte is refused.
    for (int i = 0; i < 4; i++) begin
      rx_send(8'(8'h50 + i));
      exp_q.push_back(32'h50 + 32'(i));
    end
    rx_data = 8'h99; rx_valid = 1'b1;
    io_read(8'h04, rd); check_eq("rx_pop_full", rd, exp_q.pop_front());
    rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      io_read(8'h04, rd); check_eq("rx_pop_rest", rd, exp_q.pop_front());
    end
    io_read(8'h00, rd); check_eq("rxctl_no_push", rd, 32'h0);

    // TX: five stores with the UART stalled; fifth overflows.
    for (int i = 0; i < 5; i++) begin
      io_write(8'h0C, 32'h11 + 32'(i));
      if (i < 4) exp_q.push_back(32'h11 + 32'(i));
    end
    io_read(8'h08, rd); check_eq("txctl_ovf_full", rd, 32'h2);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("tx_valid_drain", tx_valid, 32'h1);
      check_eq("tx_data_drain", tx_data, exp_q.pop_front());
      @(negedge clk);
    end
    tx_ready = 1'b0;
    #1;
    check_eq("tx_valid_empty", tx_valid, 32'h0);
    check_eq("tx_data_empty", tx_data, 32'h0);
    io_read(8'h08, rd); check_eq("txctl_ovf_sticky", rd, 32'h3);
    io_write(8'h08, 32'd0);
    io_read(8'h08, rd); check_eq("txctl_ovf_clr", rd, 32'h1);

    // TX full with push and pop together: pop happens, push dropped.
    for (int i = 0; i < 4; i++) begin
      io_write(8'h0C, 32'hA0 + 32'(i));
      exp_q.push_back(32'hA0 + 32'(i));
    end
    tx_ready = 1'b1;
    #1 check_eq("tx_head_full", tx_data, exp_q.pop_front());
    io_write(8'h0C, 32'hA4);
    tx_ready = 1'b0;
    io_read(8'h08, rd); check_eq("txctl_pushpop_full", rd, 32'h3);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("tx_data_rest", tx_data, exp_q.pop_front());
      @(negedge clk);
    end
    tx_ready = 1'b0;
    #1 check_eq("tx_valid_rest", tx_valid, 32'h0);

    // TX not full with push and pop together: count unchanged.
    io_write(8'h08, 32'd0);
    io_write(8'h0C, 32'h55);
    tx_ready = 1'b1;
    #1 check_eq("tx_head_55", tx_data, 32'h55);
    io_write(8'h0C, 32'h66);
    tx_ready = 1'b0;
    #1 check_eq("tx_head_66", tx_data, 32'h66);
    io_read(8'h08, rd); check_eq("txctl_pushpop", rd, 32'h1);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    #1 check_eq("tx_valid_one", tx_valid, 32'h0);

    // Non-IO load does not touch the RX FIFO.
    rx_send(8'h77);
    addr = 32'h5000_0000; load_en = 1'b1; #1;
    check_eq("r5_load_io_sel", load_io_sel, 32'h0);
    check_eq("r5_io_rdata", io_rdata, 32'h0);
    @(negedge clk);
    drive_idle();
    io_read(8'h00, rd); check_eq("rxctl_after_r5", rd, 32'h1);
    io_read(8'h20, rd); check_eq("io_unlisted", rd, 32'h0);
    io_read(8'h04, rd); check_eq("rx_after_r5", rd, 32'h77);

    // Reset mid-stream discards queued RX bytes.
    rx_send(8'h61);
    rx_send(8'h62);
    rst = 1'b1;
    #1 check_eq("rst_mid_rx_ready", rx_ready, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    io_read(8'h00, rd); check_eq("rxctl_after_rst", rd, 32'h0);
    #1 check_eq("rx_ready_after_rst", rx_ready, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
